nor_vector_checker: RTL and testbench
=====================================

NOR_VECTOR_CHECKER -- requirements
Module: nor_vector_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of vector and error counters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins a checking run.
REQ-005 in_valid  in  1  sample on a,b,c,f3,f4 is valid this cycle.
REQ-006 a, b, c  in  1 each  applied input vector of the 3-input NOR under test.
REQ-007 f3, f4  in  1 each  observed NOR outputs for that vector.
REQ-008 in_ready  out  1  checker accepts a sample this cycle.
REQ-009 busy  out  1  run in progress.
REQ-010 done  out  1  run finished; held until start or rst.
REQ-011 pass  out  1  valid while done: run finished with zero mismatches.
REQ-012 vec_count  out  CNT_W  accepted samples this run.
REQ-013 err_count  out  CNT_W  mismatching samples this run.
REQ-014 coverage  out  8  bit {a,b,c} set once that vector has been accepted.
REQ-015 first_err_vec  out  3  {a,b,c} of first mismatching sample; valid when err_count != 0.

Function
REQ-016 States IDLE, RUN, DONE; encoded as a 2-bit enumerated type.
REQ-017 IDLE: in_ready=0, busy=0, done=0; start moves to RUN and clears vec_count, err_count, coverage, first_err_vec on the same edge.
REQ-018 RUN: in_ready=1, busy=1; a sample is accepted on an edge where in_valid=1 and in_ready=1.
REQ-019 Expected values: exp_f3 = NOT(a OR b OR c); exp_f4 = NOT(NOT(a OR b) OR c).
REQ-020 Mismatch when f3 != exp_f3 or f4 != exp_f4.
REQ-021 On acceptance: vec_count+1, coverage[{a,b,c}] set, err_count+1 on mismatch; results visible the cycle after the accepting edge (latency 1).
REQ-022 first_err_vec is loaded only on the accepting edge of the first mismatch (err_count==0 before the edge); later mismatches leave it unchanged.
REQ-023 vec_count and err_count saturate at 2^CNT_W-1; no wrap-around.
REQ-024 RUN -> DONE on the accepting edge whose update makes coverage 8'hFF; this sample is counted and checked.
REQ-025 Repeated vectors in RUN are counted and checked; coverage bit stays set.
REQ-026 start while in RUN is ignored.
REQ-027 DONE: in_ready=0, busy=0, done=1, pass=(err_count==0); all counters frozen; in_valid ignored.
REQ-028 start in DONE moves to RUN with the same clears as REQ-017.
REQ-029 pass=0 whenever done=0.

Reset
REQ-030 rst=1 on a rising edge forces IDLE and zeroes every output register (vec_count, err_count, coverage, first_err_vec, done, pass, busy, in_ready).
REQ-031 rst has priority over start and in_valid on the same edge, including mid-run; no sample is accepted on a reset edge.

Structure
REQ-032 A shared package holds the state enumeration, CNT_W default, and the function computing {exp_f3, exp_f4} from {a,b,c}.
REQ-033 One sub-module, nor_sat_counter (CNT_W-bit saturating increment with synchronous clear), is instantiated twice: once for vec_count and once for err_count.

Verification
REQ-034 rst, start, 8 correct vectors 000..111 with in_valid held -> done=1, pass=1, vec_count=8, err_count=0, coverage=FF one cycle after the 8th accept.
REQ-035 Vector 011 with f3=1 (wrong), all others correct -> err_count=1, first_err_vec=3'b011, pass=0.
REQ-036 CNT_W=3: vector 000 applied 10 times, no others -> vec_count saturates at 7, state stays RUN, coverage=01.
REQ-037 rst asserted after 4 accepts with in_valid=1 on the same edge -> next cycle all outputs 0, state IDLE, in_ready=0.
REQ-038 start pulse mid-run after 3 accepts -> counters keep counting (vec_count=4 after next accept); start in DONE -> counters cleared, busy=1.
REQ-039 in_valid pulses in IDLE and DONE -> vec_count, coverage unchanged.

Source files
------------

// File: rtl/nor_vector_checker_pkg.sv
// nor_vector_checker_pkg: shared state enum, default counter width and NOR reference function
package nor_vector_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int CNT_W_DEF = 8;
  function automatic logic [1:0] exp_nor(input logic [2:0] v);
    return {~|v, ~(~(v[2] | v[1]) | v[0])};
  endfunction
endpackage

// File: rtl/nor_sat_counter.sv
// nor_sat_counter: W-bit saturating up-counter (clk, rst, clr sync clear, inc, q)
module nor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/nor_vector_checker.sv
// nor_vector_checker: checks observed f3/f4 of a 3-input NOR against reference; start/in_valid/a/b/c/f3/f4 in, in_ready/busy/done/pass/counters/coverage/first_err_vec out
module nor_vector_checker
  import nor_vector_checker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             f3,
  input  logic             f4,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic [2:0]       first_err_vec
);
  state_t state, state_nx;
  logic [2:0] v;
  logic accept, clr, mism;
  logic [7:0] cov_nx;
  assign v = {a, b, c};
  always_comb begin
    accept = state == RUN && in_valid;
    clr = start && state != RUN;
    mism = exp_nor(v) != {f3, f4};
    cov_nx = coverage | (8'd1 << v);
    state_nx = clr ? RUN : (accept && cov_nx == 8'hFF) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      coverage <= '0;
      first_err_vec <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        coverage <= '0;
        first_err_vec <= '0;
      end else if (accept) begin
        coverage <= cov_nx;
        if (mism && err_count == '0) first_err_vec <= v;
      end
    end
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  nor_sat_counter #(.W(CNT_W)) u_vec (.clk(clk), .rst(rst), .clr(clr), .inc(accept), .q(vec_count));
  nor_sat_counter #(.W(CNT_W)) u_err (.clk(clk), .rst(rst), .clr(clr), .inc(accept && mism), .q(err_count));
endmodule

// File: tb/tb_nor_vector_checker.sv
// tb_nor_vector_checker: directed bench with a behavioural model, per-cycle compare and literal checkpoints
module tb_nor_vector_checker;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, a = 0, b = 0, c = 0, f3 = 0, f4 = 0;
  logic in_ready, busy, done, pass;
  logic [7:0] vec_count, err_count, coverage;
  logic [2:0] first_err_vec;
  logic in_ready3, busy3, done3, pass3;
  logic [2:0] vec3, err3, fev3;
  logic [7:0] cov3;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [7:0] f3_tab = 8'h01, f4_tab = 8'h54;
  bit m_run = 0, m_fin = 0;
  int m_vec = 0, m_err = 0;
  logic [7:0] m_cov = 0;
  logic [2:0] m_first = 0;

  always #5 clk = ~clk;

  nor_vector_checker dut (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .f3(f3), .f4(f4), .in_ready(in_ready), .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
    .err_count(err_count), .coverage(coverage), .first_err_vec(first_err_vec));
  nor_vector_checker #(.CNT_W(3)) dut3 (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .f3(f3), .f4(f4), .in_ready(in_ready3), .busy(busy3), .done(done3), .pass(pass3), .vec_count(vec3),
    .err_count(err3), .coverage(cov3), .first_err_vec(fev3));

  function automatic int sat(input int n, input int w);
    return n > (1 << w) - 1 ? (1 << w) - 1 : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic mm;
    logic [7:0] nc;
    mm = (f3 != !(a || b || c)) || (f4 != !(!(a || b) || c));
    nc = m_cov | (8'd1 << {a, b, c});
    if (rst) begin
      m_run <= 0; m_fin <= 0; m_vec <= 0; m_err <= 0; m_cov <= 0; m_first <= 0;
    end else if (start && !m_run) begin
      m_run <= 1; m_fin <= 0; m_vec <= 0; m_err <= 0; m_cov <= 0; m_first <= 0;
    end else if (m_run && in_valid) begin
      m_vec <= m_vec + 1;
      m_err <= m_err + int'(mm);
      m_cov <= nc;
      if (mm && m_err == 0) m_first <= {a, b, c};
      if (nc == 8'hFF) begin
        m_run <= 0;
        m_fin <= 1;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_fin);
    chk("pass", pass, m_fin && m_err == 0);
    chk("vec_count", vec_count, sat(m_vec, 8));
    chk("err_count", err_count, sat(m_err, 8));
    chk("coverage", coverage, m_cov);
    if (m_err != 0) chk("first_err_vec", first_err_vec, m_first);
    chk("busy3", busy3, m_run);
    chk("done3", done3, m_fin);
    chk("vec3", vec3, sat(m_vec, 3));
    chk("err3", err3, sat(m_err, 3));
    chk("cov3", cov3, m_cov);
  end

  task automatic step(input bit r, input bit s, input bit iv, input logic [2:0] v, input bit bad3);
    @(negedge clk);
    rst = r; start = s; in_valid = iv; {a, b, c} = v;
    f3 = f3_tab[v] ^ bad3;
    f4 = f4_tab[v];
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 0);
  endtask

  initial begin
    step(1, 0, 0, 3'd0, 0);
    step(1, 1, 1, 3'd0, 0);
    @(posedge clk);
    chk_en = 1;
    idle();
    chk("rst_vec", vec_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    step(0, 1, 0, 3'd0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), 0);
    idle();
    chk("all_done", done, 1);
    chk("all_pass", pass, 1);
    chk("all_vec", vec_count, 8);
    chk("all_err", err_count, 0);
    chk("all_cov", coverage, 8'hFF);
    step(0, 0, 1, 3'd5, 1);
    idle();
    chk("done_freeze_vec", vec_count, 8);
    chk("done_freeze_err", err_count, 0);
    step(0, 1, 0, 3'd0, 0);
    idle();
    chk("restart_busy", busy, 1);
    chk("restart_vec", vec_count, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), i == 3);
    idle();
    chk("bad_err", err_count, 1);
    chk("bad_first", first_err_vec, 3'b011);
    chk("bad_pass", pass, 0);
    chk("bad_done", done, 1);
    step(0, 1, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'(i), 0);
    step(0, 1, 0, 3'd0, 0);
    step(0, 0, 1, 3'd3, 0);
    idle();
    chk("midstart_vec", vec_count, 4);
    chk("midstart_busy", busy, 1);
    step(1, 1, 1, 3'd4, 1);
    idle();
    chk("midrst_vec", vec_count, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_cov", coverage, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    step(0, 0, 1, 3'd6, 0);
    idle();
    chk("idle_vec", vec_count, 0);
    chk("idle_cov", coverage, 0);
    step(0, 1, 0, 3'd0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 3'd0, 0);
    idle();
    chk("sat3_vec", vec3, 7);
    chk("sat8_vec", vec_count, 10);
    chk("sat3_busy", busy3, 1);
    chk("sat3_cov", cov3, 8'h01);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
